cpu_req_gen: RTL and testbench

CPU_REQ_GEN -- requirements
Module: cpu_req_gen

---
 rtl/cpu_req_gen_if.sv | 29 ++
 rtl/cpu_req_gen.sv | 148 ++++++++++++++
 tb/tb_cpu_req_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_req_gen_if.sv
// CPU-side request bus between the request generator and a cache model.
// The generator drives the request/status signals and the cache side drives start/mode/base/trig.
interface cpu_req_gen_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] base;
    logic                  trig;
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_rd;
    logic                  cs;
    logic [DATA_WIDTH-1:0] dout;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [15:0]           req_count;

    modport master (
        input  start, mode, base, trig,
        output address, wr_rd, cs, dout, busy, done, error, req_count
    );

    modport slave (
        output start, mode, base, trig,
        input  address, wr_rd, cs, dout, busy, done, error, req_count
    );
endinterface

// File: rtl/cpu_req_gen.sv
// Generates a run of NUM_REQ CPU requests with a selectable address pattern.
// Each request is a one-cycle cs strobe, followed by a wait for trig that is bounded by TIMEOUT.
module cpu_req_gen #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 32,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned STRIDE     = 4
) (
    input logic            clk,
    input logic            rst,
    cpu_req_gen_if.master  bus
);
    localparam int unsigned WCNT_W    = $clog2(TIMEOUT);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_e;

    state_e                state_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           lfsr_q;
    logic [15:0]           req_count_q;
    logic [WCNT_W-1:0]     wait_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_rd_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  cs_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  idle_like;
    logic [1:0]            src_mode;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [15:0]           src_lfsr;
    logic [15:0]           src_idx;
    logic [15:0]           count_inc;
    logic                  last_req;
    logic [15:0]           lfsr_shift;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  wr_rd_d;
    logic [DATA_WIDTH-1:0] dout_d;

    assign idle_like  = !((state_q == S_ISSUE) || (state_q == S_WAIT));
    assign count_inc  = req_count_q + 16'd1;
    assign last_req   = (count_inc == 16'(NUM_REQ));
    assign lfsr_shift = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // Fields of the next request: a fresh run takes the live inputs, later requests the latched run setup.
    always_comb begin
        src_mode = mode_q;
        src_base = base_q;
        src_lfsr = lfsr_q;
        src_idx  = count_inc;
        addr_d   = '0;
        if (idle_like) begin
            src_mode = bus.mode;
            src_base = bus.base;
            src_lfsr = LFSR_SEED;
            src_idx  = '0;
        end
        case (src_mode)
            2'b00:   addr_d = src_base + ADDR_WIDTH'(src_idx);
            2'b01:   addr_d = src_lfsr[ADDR_WIDTH-1:0];
            2'b10:   addr_d = src_base + ADDR_WIDTH'(src_idx) * ADDR_WIDTH'(STRIDE);
            default: addr_d = src_base + ADDR_WIDTH'(src_idx[1:0]);
        endcase
        wr_rd_d = (src_mode == 2'b01) ? src_lfsr[15] : ~src_idx[0];
        dout_d  = src_idx[DATA_WIDTH-1:0] ^ addr_d[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            req_count_q <= '0;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            wr_rd_q     <= 1'b0;
            dout_q      <= '0;
            cs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    cs_q       <= 1'b0;
                    lfsr_q     <= lfsr_shift;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // trig takes priority over a timeout that expires in the same cycle
                    if (bus.trig) begin
                        req_count_q <= count_inc;
                        if (last_req) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            cs_q    <= 1'b1;
                            addr_q  <= addr_d;
                            wr_rd_q <= wr_rd_d;
                            dout_q  <= dout_d;
                        end
                    end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                    if (bus.start) begin
                        mode_q      <= bus.mode;
                        base_q      <= bus.base;
                        lfsr_q      <= LFSR_SEED;
                        req_count_q <= '0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        cs_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        addr_q      <= addr_d;
                        wr_rd_q     <= wr_rd_d;
                        dout_q      <= dout_d;
                        state_q     <= S_ISSUE;
                    end
                end
            endcase
        end
    end

    assign bus.address   = addr_q;
    assign bus.wr_rd     = wr_rd_q;
    assign bus.cs        = cs_q;
    assign bus.dout      = dout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.req_count = req_count_q;
endmodule

// File: tb/tb_cpu_req_gen.sv
// Scoreboard bench for cpu_req_gen: stimulus queues the expected requests, and per-instance monitors check each cs strobe.
// Three instances cover run lengths of 4, 3 and 6 requests.
module tb_cpu_req_gen;
    logic clk;
    logic rst;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  dout;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   trig_en_a = 1'b1;
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   cnt_c = 0;

    cpu_req_gen_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifa ();
    cpu_req_gen_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifb ();
    cpu_req_gen_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifc ();

    cpu_req_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(4), .TIMEOUT(64), .STRIDE(4))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    cpu_req_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(3), .TIMEOUT(64), .STRIDE(4))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    cpu_req_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_REQ(6), .TIMEOUT(64), .STRIDE(4))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push(input int w, input logic [15:0] a, input logic wr, input logic [7:0] d);
        exp_t e;
        e = '{addr: a, wr: wr, dout: d};
        case (w)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic mon(input int w, input logic [15:0] a, input logic wr, input logic [7:0] d);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (w)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_total++;
            $display("FAIL unexpected_cs[%0d]: got cs=1 at address %0h, required no request", w, a);
        end else begin
            chk($sformatf("address[%0d]", w), 32'(a), 32'(e.addr));
            chk($sformatf("wr_rd[%0d]", w), 32'(wr), 32'(e.wr));
            chk($sformatf("dout[%0d]", w), 32'(d), 32'(e.dout));
        end
    endtask

    // Monitors: every cs strobe is matched against the head of its instance's queue
    always @(negedge clk) begin
        if (!rst && ifa.cs) mon(0, ifa.address, ifa.wr_rd, ifa.dout);
        if (!rst && ifb.cs) mon(1, ifb.address, ifb.wr_rd, ifb.dout);
        if (!rst && ifc.cs) mon(2, ifc.address, ifc.wr_rd, ifc.dout);
    end

    // Cache model: trig is raised 3 cycles after each cs
    always @(negedge clk) begin
        ifa.trig = 1'b0;
        ifb.trig = 1'b0;
        ifc.trig = 1'b0;
        if (trig_en_a && ifa.cs) cnt_a = 3;
        else if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) ifa.trig = 1'b1; end
        if (ifb.cs) cnt_b = 3;
        else if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) ifb.trig = 1'b1; end
        if (ifc.cs) cnt_c = 3;
        else if (cnt_c > 0) begin cnt_c--; if (cnt_c == 0) ifc.trig = 1'b1; end
    end

    function automatic logic busy_of(input int w);
        case (w)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    task automatic go(input int w, input logic [1:0] m, input logic [15:0] b);
        @(negedge clk);
        case (w)
            0:       begin ifa.mode = m; ifa.base = b; ifa.start = 1'b1; end
            1:       begin ifb.mode = m; ifb.base = b; ifb.start = 1'b1; end
            default: begin ifc.mode = m; ifc.base = b; ifc.start = 1'b1; end
        endcase
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
    endtask

    task automatic wait_idle(input int w, input string name);
        int k;
        k = 0;
        while (busy_of(w) && k < 1000) begin @(negedge clk); k++; end
        chk({name, "_run_finished"}, 32'(busy_of(w)), 32'd0);
    endtask

    task automatic wait_cs_a(input string name);
        int k;
        k = 0;
        while (!ifa.cs && k < 200) begin @(negedge clk); k++; end
        chk({name, "_cs_seen"}, 32'(ifa.cs), 32'd1);
    endtask

    task automatic push_lfsr_run();
        push(0, 16'hACE1, 1'b1, 8'hE1);
        push(0, 16'hE270, 1'b1, 8'h71);
        push(0, 16'h7138, 1'b0, 8'h3A);
        push(0, 16'h389C, 1'b0, 8'h9F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.mode = 2'b00; ifa.base = 16'h0;
        ifb.start = 1'b0; ifb.mode = 2'b00; ifb.base = 16'h0;
        ifc.start = 1'b0; ifc.mode = 2'b00; ifc.base = 16'h0;

        // Reset values, observed before the first clock edge
        #2;
        chk("rst_address", 32'(ifa.address), 32'd0);
        chk("rst_dout", 32'(ifa.dout), 32'd0);
        chk("rst_req_count", 32'(ifa.req_count), 32'd0);
        chk("rst_flags", 32'({ifa.cs, ifa.wr_rd, ifa.busy, ifa.done, ifa.error}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", 32'({ifa.cs, ifa.busy, ifb.busy, ifc.busy}), 32'd0);

        // Sequential mode
        push(0, 16'h0010, 1'b1, 8'h10);
        push(0, 16'h0011, 1'b0, 8'h10);
        push(0, 16'h0012, 1'b1, 8'h10);
        push(0, 16'h0013, 1'b0, 8'h10);
        go(0, 2'b00, 16'h0010);
        wait_idle(0, "seq");
        chk("seq_done", 32'(ifa.done), 32'd1);
        chk("seq_error", 32'(ifa.error), 32'd0);
        chk("seq_req_count", 32'(ifa.req_count), 32'd4);

        // Stride mode wrapping past the top of the address space
        push(1, 16'hFFF8, 1'b1, 8'hF8);
        push(1, 16'hFFFC, 1'b0, 8'hFD);
        push(1, 16'h0000, 1'b1, 8'h02);
        go(1, 2'b10, 16'hFFF8);
        wait_idle(1, "stride");
        chk("stride_done", 32'(ifb.done), 32'd1);
        chk("stride_req_count", 32'(ifb.req_count), 32'd3);

        // Hit-loop mode cycling over four addresses
        push(2, 16'h0100, 1'b1, 8'h00);
        push(2, 16'h0101, 1'b0, 8'h00);
        push(2, 16'h0102, 1'b1, 8'h00);
        push(2, 16'h0103, 1'b0, 8'h00);
        push(2, 16'h0100, 1'b1, 8'h04);
        push(2, 16'h0101, 1'b0, 8'h04);
        go(2, 2'b11, 16'h0100);
        wait_idle(2, "hit");
        chk("hit_done", 32'(ifc.done), 32'd1);
        chk("hit_req_count", 32'(ifc.req_count), 32'd6);

        // Timeout: no trig, so error must rise 64 cycles after WAIT is entered
        trig_en_a = 1'b0;
        push(0, 16'h0200, 1'b1, 8'h00);
        go(0, 2'b00, 16'h0200);
        chk("to_issue_cs", 32'(ifa.cs), 32'd1);
        k = 0;
        while (!ifa.error && k < 200) begin @(negedge clk); k++; end
        chk("to_latency", 32'(k), 32'd65);
        chk("to_error", 32'(ifa.error), 32'd1);
        chk("to_busy", 32'(ifa.busy), 32'd0);
        chk("to_done", 32'(ifa.done), 32'd0);
        chk("to_req_count", 32'(ifa.req_count), 32'd0);
        repeat (10) @(negedge clk);
        trig_en_a = 1'b1;

        // Start during WAIT is ignored; reset during the second request's WAIT aborts the run
        push(0, 16'h0300, 1'b1, 8'h00);
        push(0, 16'h0301, 1'b0, 8'h00);
        go(0, 2'b00, 16'h0300);
        chk("ign_first_cs", 32'(ifa.cs), 32'd1);
        @(negedge clk);
        ifa.mode = 2'b11; ifa.base = 16'h0500; ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_cs_a("ign_second");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_address", 32'(ifa.address), 32'd0);
        chk("arst_dout", 32'(ifa.dout), 32'd0);
        chk("arst_req_count", 32'(ifa.req_count), 32'd0);
        chk("arst_flags", 32'({ifa.cs, ifa.wr_rd, ifa.busy, ifa.done, ifa.error}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("arst_stays_idle", 32'({ifa.busy, ifa.done, ifa.error}), 32'd0);
        chk("arst_count_held", 32'(ifa.req_count), 32'd0);

        // LFSR mode, two identical runs give the same sequence
        push_lfsr_run();
        go(0, 2'b01, 16'h1234);
        wait_idle(0, "lfsr1");
        chk("lfsr1_done", 32'(ifa.done), 32'd1);
        push_lfsr_run();
        go(0, 2'b01, 16'h1234);
        wait_idle(0, "lfsr2");
        chk("lfsr2_done", 32'(ifa.done), 32'd1);
        chk("lfsr2_req_count", 32'(ifa.req_count), 32'd4);

        repeat (5) @(negedge clk);
        chk("pending_requests", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
